// File: rtl/knn_inst_fetch.sv
// Instruction fetch stage for the kNN RISC-V accelerator: on-chip program memory,
// PC sequencing with blt redirect, stall hold, issue counting and end-of-program detection.
module knn_inst_fetch #(
  parameter int          IMEM_DEPTH = 1024,
  parameter int          PC_W       = 10,
  parameter logic [31:0] NOP_INST   = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [PC_W-1:0] prog_len,
  input  logic            imem_we,
  input  logic [PC_W-1:0] imem_waddr,
  input  logic [31:0]     imem_wdata,
  input  logic            stall,
  input  logic            pc_branch,
  input  logic            branch_taken,
  input  logic [11:0]     branch_imm,
  output logic [31:0]     inst_code,
  output logic            inst_valid,
  output logic [PC_W-1:0] pc,
  output logic [9:0]      cnt,
  output logic            done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int              AW       = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam bit              FULL_MAP = (IMEM_DEPTH >= (1 << PC_W));
  localparam logic [PC_W-1:0] PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [9:0]      CNT_MAX  = 10'd1023;

  logic [31:0]     r_mem [IMEM_DEPTH];
  logic [1:0]      r_state;
  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] r_raddr;
  logic [31:0]     r_rdata;
  logic [PC_W-1:0] r_prog_len;
  logic [31:0]     r_inst_code;
  logic            r_inst_valid;
  logic [PC_W-1:0] r_pc;
  logic [9:0]      r_cnt;
  logic            r_done;

  logic            w_load_ok;
  logic            w_issue;
  logic            w_take;
  logic [PC_W-1:0] w_offset;
  logic [PC_W-1:0] w_target;
  logic [PC_W:0]   w_next_issue;
  logic            w_end;
  logic            w_ren;
  logic [PC_W-1:0] w_raddr;
  logic            w_raddr_ok;
  logic            w_waddr_ok;
  logic            w_mem_we;

  assign w_load_ok = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_issue   = (r_state == S_RUN) && r_inst_valid && !stall;
  assign w_take    = w_issue && pc_branch && branch_taken;

  // branch_imm is a halfword offset; the arithmetic shift turns it into words and drops bit 0
  assign w_offset = PC_W'($signed({{20{branch_imm[11]}}, branch_imm}) >>> 1);
  assign w_target = r_pc + w_offset;

  assign w_next_issue = w_take ? {1'b0, w_target} : ({1'b0, r_pc} + {{PC_W{1'b0}}, 1'b1});
  assign w_end        = w_issue && (w_next_issue >= {1'b0, r_prog_len});

  assign w_ren   = (r_state == S_FILL) || ((r_state == S_RUN) && !stall && !w_end);
  assign w_raddr = w_take ? w_target : r_fetch_pc;

  generate
    if (FULL_MAP) begin : g_full_map
      assign w_raddr_ok = 1'b1;
      assign w_waddr_ok = 1'b1;
    end else begin : g_partial_map
      assign w_raddr_ok = (32'(w_raddr) < IMEM_DEPTH);
      assign w_waddr_ok = (32'(imem_waddr) < IMEM_DEPTH);
    end
  endgenerate

  assign w_mem_we = imem_we && w_load_ok && w_waddr_ok;

  // Program memory: unreset so it maps onto block RAM; read-before-write, one cycle latency
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[imem_waddr[AW-1:0]] <= imem_wdata;
    end
    if (w_ren) begin
      r_rdata <= w_raddr_ok ? r_mem[w_raddr[AW-1:0]] : NOP_INST;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_fetch_pc   <= '0;
      r_raddr      <= '0;
      r_prog_len   <= '0;
      r_inst_code  <= NOP_INST;
      r_inst_valid <= 1'b0;
      r_pc         <= '0;
      r_cnt        <= '0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_prog_len <= prog_len;
            r_fetch_pc <= '0;
            r_cnt      <= '0;
            if (prog_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_FILL;
              r_done  <= 1'b0;
            end
          end
        end

        S_FILL: begin
          r_raddr    <= r_fetch_pc;
          r_fetch_pc <= r_fetch_pc + PC_ONE;
          r_state    <= S_RUN;
        end

        S_RUN: begin
          if (!stall) begin
            if (w_issue && (r_cnt != CNT_MAX)) begin
              r_cnt <= r_cnt + 10'd1;
            end
            // r_raddr tracks which word r_rdata holds, so it becomes pc on issue
            if (w_end) begin
              r_state      <= S_DONE;
              r_inst_code  <= NOP_INST;
              r_inst_valid <= 1'b0;
              r_done       <= 1'b1;
            end else if (w_take) begin
              r_inst_code  <= NOP_INST;
              r_inst_valid <= 1'b0;
              r_raddr      <= w_target;
              r_fetch_pc   <= w_target + PC_ONE;
            end else begin
              r_inst_code  <= r_rdata;
              r_pc         <= r_raddr;
              r_inst_valid <= 1'b1;
              r_raddr      <= r_fetch_pc;
              r_fetch_pc   <= r_fetch_pc + PC_ONE;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign inst_code  = r_inst_code;
  assign inst_valid = r_inst_valid;
  assign pc         = r_pc;
  assign cnt        = r_cnt;
  assign done       = r_done;

endmodule
